// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU in EX.
// Produces {remainder, quotient} one quotient bit per cycle and holds the
// pipeline via stall_req until the result is ready. annul cancels an
// in-flight division.
module div_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               signed_div,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               annul,
   output logic               stall_req,
   output logic               ready,
   output logic [2*WIDTH-1:0] result
);

   localparam int unsigned CW   = $clog2(WIDTH);
   localparam int unsigned LAST = WIDTH - 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ZERO,
      S_ON,
      S_END
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] dvd_raw;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] quo;
   logic [WIDTH:0]   rem;
   logic             neg_q;
   logic             neg_r;

   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic [WIDTH:0]   rem_nxt;
   logic [WIDTH-1:0] quo_nxt;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

   // Operand magnitudes; the most negative value maps onto itself as unsigned.
   always_comb begin
      a_mag = (signed_div && a[WIDTH-1]) ? -a : a;
      b_mag = (signed_div && b[WIDTH-1]) ? -b : b;
   end

   // One restoring shift-subtract step plus final sign correction of its outcome.
   always_comb begin
      shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
      diff    = shifted - {1'b0, dvs};
      rem_nxt = shifted;
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
      if (!diff[WIDTH]) begin
         rem_nxt    = diff;
         quo_nxt[0] = 1'b1;
      end
      q_fix = neg_q ? -quo_nxt : quo_nxt;
      r_fix = neg_r ? -rem_nxt[WIDTH-1:0] : rem_nxt[WIDTH-1:0];
   end

   // Hold EX while a start is being accepted or a division is in progress.
   assign stall_req = (start && (state == S_IDLE) && !annul) ||
                      (state == S_ZERO) || (state == S_ON);

   // Control FSM and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         ready   <= 1'b0;
         result  <= '0;
         cnt     <= '0;
         dvd_raw <= '0;
         dvs     <= '0;
         quo     <= '0;
         rem     <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
      end else begin
         ready <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start && !annul) begin
                  dvd_raw <= a;
                  dvs     <= b_mag;
                  quo     <= a_mag;
                  rem     <= '0;
                  cnt     <= '0;
                  neg_q   <= signed_div && (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_r   <= signed_div && a[WIDTH-1];
                  state   <= (b == '0) ? S_ZERO : S_ON;
               end
            end
            S_ZERO: begin
               if (annul) begin
                  state <= S_IDLE;
               end else begin
                  result <= {dvd_raw, {WIDTH{1'b1}}};
                  ready  <= 1'b1;
                  state  <= S_END;
               end
            end
            S_ON: begin
               if (annul) begin
                  state <= S_IDLE;
               end else begin
                  rem <= rem_nxt;
                  quo <= quo_nxt;
                  cnt <= cnt + CW'(1);
                  if (cnt == CW'(LAST)) begin
                     result <= {r_fix, q_fix};
                     ready  <= 1'b1;
                     state  <= S_END;
                  end
               end
            end
            S_END: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
